// File: rtl/md_issue_if.sv
// Pipeline-side handshake bundle for the mult/div issue controller:
// DX decode inputs, multdiv status, W-stage arbitration and control outputs.
interface md_issue_if #(
   parameter int REG_W = 5
);
   logic [31:0]      dx_instr;
   logic             dx_valid;
   logic             md_rdy;
   logic             md_exc;
   logic             w_busy;
   logic             start_mult;
   logic             start_div;
   logic             stall;
   logic             nop_xm;
   logic             pw_load;
   logic             wb_en;
   logic [REG_W-1:0] wb_rd;
   logic             exc_out;
   logic             timeout_flag;
   logic             busy;

   modport master (
      output dx_instr, dx_valid, md_rdy, md_exc, w_busy,
      input  start_mult, start_div, stall, nop_xm, pw_load, wb_en, wb_rd,
             exc_out, timeout_flag, busy
   );

   modport slave (
      input  dx_instr, dx_valid, md_rdy, md_exc, w_busy,
      output start_mult, start_div, stall, nop_xm, pw_load, wb_en, wb_rd,
             exc_out, timeout_flag, busy
   );
endinterface

// File: rtl/md_issue_ctrl.sv
// Mult/div issue and stall control: one outstanding operation, timeout abort,
// P/W holding latch load and write-back arbitration against the W stage.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | nothing outstanding; a decoded mult/div issues from here
// BUSY  | waiting for md_rdy, timeout counter running
// HOLD  | result latched in P/W, waiting for a free regfile write port
module md_issue_ctrl #(
   parameter bit BLOCKING = 1'b1,
   parameter int TIMEOUT  = 40,
   parameter int CNT_W    = 8,
   parameter int REG_W    = 5
) (
   input logic        clock,
   input logic        reset,
   md_issue_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [REG_W-1:0] pend_rd;
   logic             wb_q;
   logic             tflag_q;

   logic [4:0]       opcode;
   logic [4:0]       alu_op;
   logic [REG_W-1:0] rd;
   logic [REG_W-1:0] rs;
   logic [REG_W-1:0] rt;
   logic             md_op;
   logic             hazard;
   logic             tmo_hit;
   logic             hold_wb;
   logic             unused_instr_bits;

   assign opcode = bus.dx_instr[31:27];
   assign alu_op = bus.dx_instr[6:2];
   assign rd     = REG_W'(bus.dx_instr[26:22]);
   assign rs     = REG_W'(bus.dx_instr[21:17]);
   assign rt     = REG_W'(bus.dx_instr[16:12]);
   assign unused_instr_bits = ^{bus.dx_instr[11:7], bus.dx_instr[1:0]};

   always_comb begin
      md_op   = bus.dx_valid && (opcode == 5'b00000) &&
                ((alu_op == 5'b00110) || (alu_op == 5'b00111));
      // a second mult/div must wait as well as any reader of the pending rd
      hazard  = md_op || (bus.dx_valid && (pend_rd != '0) &&
                          ((rs == pend_rd) || (rt == pend_rd)));
      tmo_hit = (state == BUSY) && !bus.md_rdy && (cnt == CNT_W'(TIMEOUT));
      hold_wb = (state == HOLD) && !bus.w_busy && (pend_rd != '0);
   end

   always_comb begin
      bus.start_mult   = 1'b0;
      bus.start_div    = 1'b0;
      bus.stall        = 1'b0;
      bus.nop_xm       = 1'b0;
      bus.pw_load      = 1'b0;
      bus.wb_en        = 1'b0;
      bus.wb_rd        = '0;
      bus.exc_out      = 1'b0;
      bus.timeout_flag = 1'b0;
      bus.busy         = 1'b0;
      if (!reset) begin
         if (state == IDLE) begin
            bus.start_mult = md_op && (alu_op == 5'b00110);
            bus.start_div  = md_op && (alu_op == 5'b00111);
            bus.nop_xm     = md_op;
         end else begin
            bus.busy   = 1'b1;
            bus.stall  = BLOCKING ? 1'b1 : hazard;
            bus.nop_xm = BLOCKING ? bus.dx_valid : hazard;
         end
         bus.pw_load      = (state == BUSY) && bus.md_rdy;
         bus.exc_out      = ((state == BUSY) && bus.md_rdy && bus.md_exc) || tmo_hit;
         bus.timeout_flag = tflag_q || tmo_hit;
         bus.wb_en        = wb_q || hold_wb;
         bus.wb_rd        = bus.wb_en ? pend_rd : '0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         pend_rd <= '0;
         wb_q    <= 1'b0;
         tflag_q <= 1'b0;
      end else begin
         wb_q <= 1'b0;
         case (state)
            IDLE: begin
               // pend_rd may still feed this cycle's wb_rd; it updates at the edge
               if (md_op) begin
                  state   <= BUSY;
                  cnt     <= '0;
                  pend_rd <= rd;
               end
            end
            BUSY: begin
               if (bus.md_rdy) begin
                  if (!bus.w_busy) begin
                     state <= IDLE;
                     wb_q  <= (pend_rd != '0);
                  end else begin
                     state <= HOLD;
                  end
               end else if (cnt == CNT_W'(TIMEOUT)) begin
                  state   <= IDLE;
                  tflag_q <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            HOLD: begin
               if (!bus.w_busy) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_md_issue_ctrl.sv
// Bench for md_issue_ctrl: a blocking (TIMEOUT=40) and a non-blocking (TIMEOUT=10)
// instance share one input stream and are each checked against a transaction model.
module tb_md_issue_ctrl;
   logic        clock = 1'b0;
   logic        rst_i;
   logic [31:0] instr_i;
   logic        valid_i, rdy_i, exc_i, wbusy_i;

   md_issue_if #(.REG_W(5)) ifa ();
   md_issue_if #(.REG_W(5)) ifb ();

   assign ifa.dx_instr = instr_i;  assign ifb.dx_instr = instr_i;
   assign ifa.dx_valid = valid_i;  assign ifb.dx_valid = valid_i;
   assign ifa.md_rdy   = rdy_i;    assign ifb.md_rdy   = rdy_i;
   assign ifa.md_exc   = exc_i;    assign ifb.md_exc   = exc_i;
   assign ifa.w_busy   = wbusy_i;  assign ifb.w_busy   = wbusy_i;

   md_issue_ctrl #(.BLOCKING(1'b1), .TIMEOUT(40), .CNT_W(8), .REG_W(5))
      dut_a (.clock(clock), .reset(rst_i), .bus(ifa.slave));
   md_issue_ctrl #(.BLOCKING(1'b0), .TIMEOUT(10), .CNT_W(8), .REG_W(5))
      dut_b (.clock(clock), .reset(rst_i), .bus(ifb.slave));

   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // model of each instance: an outstanding op with its age and destination,
   // whether its result is parked, a write-back due next cycle, the sticky flag
   bit         blk[2] = '{1'b1, 1'b0};
   int         tmo[2] = '{40, 10};
   bit         outst[2], held[2], wbp[2], tfl[2];
   int         age[2];
   logic [4:0] prd[2];
   bit         n_outst[2], n_held[2], n_wbp[2], n_tfl[2];
   int         n_age[2];
   logic [4:0] n_prd[2];

   typedef struct {
      logic        rst;
      logic [31:0] instr;
      logic        valid, rdy, exc, wbusy;
      logic [8:0]  exp;
      logic [4:0]  exp_rd;
   } vec_t;
   vec_t tbl[12];

   function automatic logic [31:0] mk(input logic [4:0] op, rd, rs, rt, alu);
      return {op, rd, rs, rt, 5'd0, alu, 2'b00};
   endfunction

   function automatic logic [13:0] outv(input int m);
      if (m == 0)
         return {ifa.start_mult, ifa.start_div, ifa.stall, ifa.nop_xm, ifa.pw_load,
                 ifa.wb_en, ifa.exc_out, ifa.timeout_flag, ifa.busy, ifa.wb_rd};
      return {ifb.start_mult, ifb.start_div, ifb.stall, ifb.nop_xm, ifb.pw_load,
              ifb.wb_en, ifb.exc_out, ifb.timeout_flag, ifb.busy, ifb.wb_rd};
   endfunction

   task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp);
      end
   endtask

   task automatic model_eval(input int m, output logic [8:0] ev, output logic [4:0] erd);
      logic [4:0] op, alu, rd, rs, rt;
      bit md_op, hz, smul, sdiv, st, nop, pw, wb, exc, tnow;
      op = instr_i[31:27]; rd = instr_i[26:22]; rs = instr_i[21:17];
      rt = instr_i[16:12]; alu = instr_i[6:2];
      smul = 0; sdiv = 0; st = 0; nop = 0; pw = 0; exc = 0; tnow = 0;
      n_outst[m] = outst[m]; n_held[m] = held[m]; n_tfl[m] = tfl[m];
      n_age[m] = age[m]; n_prd[m] = prd[m]; n_wbp[m] = 0;
      if (rst_i) begin
         n_outst[m] = 0; n_held[m] = 0; n_tfl[m] = 0; n_age[m] = 0; n_prd[m] = 0;
         ev = '0; erd = '0;
         return;
      end
      md_op = valid_i && op == 0 && (alu == 5'd6 || alu == 5'd7);
      hz = md_op || (valid_i && prd[m] != 0 && (rs == prd[m] || rt == prd[m]));
      wb = wbp[m];
      if (!outst[m]) begin
         if (md_op) begin
            smul = (alu == 5'd6); sdiv = (alu == 5'd7); nop = 1;
            n_outst[m] = 1; n_held[m] = 0; n_age[m] = 0; n_prd[m] = rd;
         end
      end else begin
         st  = blk[m] ? 1'b1 : hz;
         nop = blk[m] ? valid_i : hz;
         if (!held[m]) begin
            if (rdy_i) begin
               pw = 1; exc = exc_i;
               if (!wbusy_i) begin n_outst[m] = 0; n_wbp[m] = (prd[m] != 0); end
               else n_held[m] = 1;
            end else if (age[m] == tmo[m]) begin
               exc = 1; tnow = 1; n_tfl[m] = 1; n_outst[m] = 0;
            end else n_age[m] = age[m] + 1;
         end else if (!wbusy_i) begin
            wb = (prd[m] != 0); n_outst[m] = 0; n_held[m] = 0;
         end
      end
      ev  = {smul, sdiv, st, nop, pw, wb, exc, tfl[m] | tnow, outst[m]};
      erd = wb ? prd[m] : 5'd0;
   endtask

   task automatic apply(input logic r, input logic [31:0] in, input logic v, rdy,
                        input logic ex, wbz);
      logic [8:0] ev;
      logic [4:0] er;
      rst_i = r; instr_i = in; valid_i = v; rdy_i = rdy; exc_i = ex; wbusy_i = wbz;
      #1;
      for (int m = 0; m < 2; m++) begin
         model_eval(m, ev, er);
         chk(m == 0 ? "model_a" : "model_b", {2'b00, outv(m)}, {2'b00, ev, er});
      end
   endtask

   task automatic tick();
      @(posedge clock);
      for (int m = 0; m < 2; m++) begin
         outst[m] = n_outst[m]; held[m] = n_held[m]; wbp[m] = n_wbp[m];
         tfl[m] = n_tfl[m]; age[m] = n_age[m]; prd[m] = n_prd[m];
      end
      cyc++;
      @(negedge clock);
   endtask

   task automatic step(input logic r, input logic [31:0] in, input logic v, rdy,
                       input logic ex, wbz);
      apply(r, in, v, rdy, ex, wbz);
      tick();
   endtask

   initial begin
      int ns, nm;
      rst_i = 1; instr_i = 0; valid_i = 0; rdy_i = 0; exc_i = 0; wbusy_i = 0;
      for (int m = 0; m < 2; m++) begin
         outst[m] = 0; held[m] = 0; wbp[m] = 0; tfl[m] = 0; age[m] = 0; prd[m] = 0;
      end

      // expected = {smul,sdiv,stall,nop_xm,pw_load,wb_en,exc,tflag,busy} of the blocking unit
      tbl[0]  = '{1'b1, 32'd0,              1'b0, 1'b0, 1'b0, 1'b0, 9'b000000000, 5'd0};
      tbl[1]  = '{1'b0, mk(0, 3, 1, 2, 6),  1'b1, 1'b0, 1'b0, 1'b0, 9'b100100000, 5'd0};
      tbl[2]  = '{1'b0, 32'd0,              1'b0, 1'b0, 1'b0, 1'b0, 9'b001000001, 5'd0};
      tbl[3]  = '{1'b0, mk(0, 7, 1, 2, 0),  1'b1, 1'b0, 1'b0, 1'b0, 9'b001100001, 5'd0};
      tbl[4]  = '{1'b0, 32'd0,              1'b0, 1'b1, 1'b0, 1'b0, 9'b001010001, 5'd0};
      tbl[5]  = '{1'b0, 32'd0,              1'b0, 1'b0, 1'b0, 1'b0, 9'b000001000, 5'd3};
      tbl[6]  = '{1'b0, 32'd0,              1'b0, 1'b0, 1'b0, 1'b0, 9'b000000000, 5'd0};
      tbl[7]  = '{1'b0, mk(0, 4, 1, 2, 7),  1'b1, 1'b0, 1'b0, 1'b0, 9'b010100000, 5'd0};
      tbl[8]  = '{1'b0, 32'd0,              1'b0, 1'b1, 1'b0, 1'b1, 9'b001010001, 5'd0};
      tbl[9]  = '{1'b0, 32'd0,              1'b0, 1'b0, 1'b0, 1'b1, 9'b001000001, 5'd0};
      tbl[10] = '{1'b0, 32'd0,              1'b0, 1'b0, 1'b0, 1'b0, 9'b001001001, 5'd4};
      tbl[11] = '{1'b0, 32'd0,              1'b0, 1'b0, 1'b0, 1'b0, 9'b000000000, 5'd0};

      @(negedge clock);
      for (int i = 0; i < 12; i++) begin
         apply(tbl[i].rst, tbl[i].instr, tbl[i].valid, tbl[i].rdy, tbl[i].exc, tbl[i].wbusy);
         chk($sformatf("table_%0d", i), {2'b00, outv(0)}, {2'b00, tbl[i].exp, tbl[i].exp_rd});
         tick();
      end

      // mult $3,$1,$2 with md_rdy 32 cycles after issue
      step(1, 0, 0, 0, 0, 0);
      ns = 0; nm = 0;
      apply(0, mk(0, 3, 1, 2, 6), 1, 0, 0, 0);
      if (ifa.start_mult) nm++;
      tick();
      for (int k = 1; k <= 32; k++) begin
         apply(0, 32'd0, 0, (k == 32), 0, 0);
         if (ifa.stall) ns++;
         if (ifa.start_mult) nm++;
         tick();
      end
      apply(0, 32'd0, 0, 0, 0, 0);
      if (ifa.stall) ns++;
      chk("seq1_wb", {10'd0, ifa.wb_en, ifa.wb_rd}, {10'd0, 1'b1, 5'd3});
      tick();
      apply(0, 32'd0, 0, 0, 0, 0);
      chk("seq1_idle", {15'd0, ifa.busy}, 16'd0);
      tick();
      chk("seq1_stall_cycles", 16'(ns), 16'd32);
      chk("seq1_start_pulses", 16'(nm), 16'd1);

      // div $5, independent add, then a reader of $5 held until write-back
      step(1, 0, 0, 0, 0, 0);
      step(0, mk(0, 5, 1, 2, 7), 1, 0, 0, 0);
      apply(0, mk(0, 7, 1, 2, 0), 1, 0, 0, 0);
      chk("seq2_no_stall", {14'd0, ifb.stall, ifb.nop_xm}, 16'd0);
      tick();
      for (int k = 0; k < 3; k++) begin
         apply(0, mk(0, 6, 5, 1, 0), 1, (k == 2), 0, 0);
         chk("seq2_raw_stall", {14'd0, ifb.stall, ifb.nop_xm}, 16'b11);
         tick();
      end
      apply(0, mk(0, 6, 5, 1, 0), 1, 0, 0, 0);
      chk("seq2_wb", {10'd0, ifb.wb_en, ifb.wb_rd}, {10'd0, 1'b1, 5'd5});
      tick();

      // result parked while W stage owns the port for 3 cycles
      step(0, mk(0, 9, 1, 2, 6), 1, 0, 0, 0);
      step(0, 32'd0, 0, 0, 0, 0);
      step(0, 32'd0, 0, 1, 0, 1);
      step(0, 32'd0, 0, 0, 0, 1);
      step(0, 32'd0, 0, 0, 0, 1);
      apply(0, 32'd0, 0, 0, 0, 0);
      chk("seq3_hold_wb", {10'd0, ifa.wb_en, ifa.wb_rd}, {10'd0, 1'b1, 5'd9});
      tick();
      step(0, 32'd0, 0, 0, 0, 0);

      // no md_rdy: both units time out, then a fresh mult issues normally
      step(0, mk(0, 2, 1, 3, 6), 1, 0, 0, 0);
      for (int k = 0; k < 45; k++) step(0, 32'd0, 0, 0, 0, 0);
      apply(0, mk(0, 2, 1, 3, 6), 1, 0, 0, 0);
      chk("seq4_tflag_sticky", {14'd0, ifa.timeout_flag, ifb.timeout_flag}, 16'b11);
      chk("seq4_reissue", {14'd0, ifa.start_mult, ifb.start_mult}, 16'b11);
      tick();
      step(0, 32'd0, 0, 1, 0, 0);
      step(0, 32'd0, 0, 0, 0, 0);

      // divide-by-zero: exception and write-back both happen
      step(0, mk(0, 4, 1, 2, 7), 1, 0, 0, 0);
      apply(0, 32'd0, 0, 1, 1, 0);
      chk("seq5_exc", {14'd0, ifa.exc_out, ifa.pw_load}, 16'b11);
      tick();
      step(0, 32'd0, 0, 0, 0, 0);

      // reset in busy cycle 5, stale md_rdy at cycle 8
      step(0, mk(0, 8, 1, 2, 6), 1, 0, 0, 0);
      for (int k = 1; k <= 9; k++) begin
         apply(k == 5, 32'd0, 0, k == 8, 0, 0);
         if (k == 8)
            chk("seq6_stale_rdy", {12'd0, ifa.pw_load, ifb.pw_load, ifa.busy, ifb.busy}, 16'd0);
         if (k == 9)
            chk("seq6_no_wb", {14'd0, ifa.wb_en, ifb.wb_en}, 16'd0);
         tick();
      end

      for (int k = 0; k < 3000; k++) begin
         logic [31:0] ins;
         logic [4:0]  rd, rs, rt;
         rd = 5'($urandom_range(0, 7)); rs = 5'($urandom_range(0, 7));
         rt = 5'($urandom_range(0, 7));
         case ($urandom_range(0, 3))
            0: ins = mk(0, rd, rs, rt, 6);
            1: ins = mk(0, rd, rs, rt, 7);
            2: ins = mk(0, rd, rs, rt, 0);
            default: ins = $urandom;
         endcase
         step($urandom_range(0, 199) == 0, ins, $urandom_range(0, 3) != 0,
              $urandom_range(0, 5) == 0, 1'($urandom_range(0, 1)),
              $urandom_range(0, 2) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
